pb_onepulse_gen: RTL and testbench

Debounces a raw, bouncing push-button input and emits exactly one single-cycle `pulse` per accepted press. It is the producer side of the single-cycle `in` strobe that the add/sub mode-toggle FSM consumes. The block also provides the debounced button level and a wrapping count of accepted presses for display and debug. Everything runs in the `clk` domain; `pb_in` is asynchronous to that domain.

---
 rtl/pb_onepulse_gen.sv | 114 +++++++++++
 tb/tb_pb_onepulse_gen.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pb_onepulse_gen.sv
// Push-button debouncer and one-shot generator.
// Synchronizes a raw bouncing button, qualifies press and release over
// STABLE_CYCLES identical samples, and emits one single-cycle pulse per press.
module pb_onepulse_gen #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned CNT_W         = 5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       pb_in_i,
  output logic       pulse_o,
  output logic       pb_level_o,
  output logic [7:0] press_cnt_o
);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StPressChk = 2'd1,
    StHeld     = 2'd2,
    StRelChk   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             pb_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic [7:0]       press_cnt_q, press_cnt_d;

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= pb_in_i;
      s2_q <= s1_q;
    end
  end

  assign pb_s = s2_q;

  // State, qualification counter, registered pulse and press counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      pulse_q     <= 1'b0;
      press_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pulse_q     <= pulse_d;
      press_cnt_q <= press_cnt_d;
    end
  end

  // Next-state logic; any run shorter than STABLE_CYCLES restarts qualification.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pulse_d     = 1'b0;
    press_cnt_d = press_cnt_q;
    case (state_q)
      StIdle: begin
        if (pb_s) begin
          state_d = StPressChk;
          cnt_d   = CNT_W'(1);
        end
      end
      StPressChk: begin
        if (!pb_s) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d     = StHeld;
          cnt_d       = '0;
          pulse_d     = 1'b1;
          press_cnt_d = press_cnt_q + 8'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StHeld: begin
        if (!pb_s) begin
          state_d = StRelChk;
          cnt_d   = CNT_W'(1);
        end
      end
      StRelChk: begin
        if (pb_s) begin
          state_d = StHeld;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  assign pulse_o     = pulse_q;
  assign pb_level_o  = (state_q == StHeld) || (state_q == StRelChk);
  assign press_cnt_o = press_cnt_q;

endmodule

// File: tb/tb_pb_onepulse_gen.sv
// Directed bench for pb_onepulse_gen with STABLE_CYCLES = 4.
module tb_pb_onepulse_gen;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       pb_in_i = 1'b0;
  logic       pulse_o;
  logic       pb_level_o;
  logic [7:0] press_cnt_o;

  int errors = 0;
  int checks = 0;
  int hi_cycles = 0;
  int rises = 0;
  logic pulse_prev = 1'b0;

  pb_onepulse_gen #(
    .STABLE_CYCLES(4),
    .CNT_W        (3)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .pb_in_i    (pb_in_i),
    .pulse_o    (pulse_o),
    .pb_level_o (pb_level_o),
    .press_cnt_o(press_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Pulse monitor sampled away from the active edge.
  always @(negedge clk_i) begin
    if (pulse_o === 1'b1) hi_cycles++;
    if (pulse_o === 1'b1 && pulse_prev !== 1'b1) rises++;
    pulse_prev = pulse_o;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  logic [8:0] bounce_vec;
  int         hi0, rise0;
  logic [7:0] base;

  initial begin
    bounce_vec = 9'b011010111;  // LSB first: 1,1,1,0,1,0,1,1,0

    // Asynchronous reset asserted mid-cycle before any clock edge.
    #2 rst_i = 1'b1;
    #1;
    chk_eq("rst_pulse", {31'd0, pulse_o}, 0);
    chk_eq("rst_level", {31'd0, pb_level_o}, 0);
    chk_eq("rst_cnt", {24'd0, press_cnt_o}, 0);
    repeat (3) step();
    rst_i = 1'b0;
    hi0 = hi_cycles;
    for (int k = 0; k < 50; k++) begin
      step();
      if (pulse_o !== 1'b0 || pb_level_o !== 1'b0 || press_cnt_o !== 8'd0)
        chk_eq("idle_outputs", {pulse_o, pb_level_o, press_cnt_o}, 0);
    end
    chk_eq("idle_nopulse", hi_cycles - hi0, 0);

    // Clean press: pb_in sampled high at edge 0, pulse only after edge 5.
    pb_in_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      chk_eq($sformatf("press_pulse_e%0d", k), {31'd0, pulse_o}, (k == 5) ? 1 : 0);
      chk_eq($sformatf("press_level_e%0d", k), {31'd0, pb_level_o}, (k >= 5) ? 1 : 0);
      chk_eq($sformatf("press_cnt_e%0d", k), {24'd0, press_cnt_o}, (k >= 5) ? 1 : 0);
    end

    // Clean release: level falls after edge 5, never a pulse.
    pb_in_i = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      chk_eq($sformatf("rel_level_e%0d", k), {31'd0, pb_level_o}, (k < 5) ? 1 : 0);
      chk_eq($sformatf("rel_pulse_e%0d", k), {31'd0, pulse_o}, 0);
    end
    chk_eq("rel_cnt", {24'd0, press_cnt_o}, 1);

    // Press bounce: runs 3,1,2 high, then final rise sampled at edge 9.
    hi0 = hi_cycles;
    for (int k = 0; k < 25; k++) begin
      pb_in_i = (k >= 9) ? 1'b1 : bounce_vec[k];
      step();
      chk_eq($sformatf("bnc_pulse_e%0d", k), {31'd0, pulse_o}, (k == 14) ? 1 : 0);
      chk_eq($sformatf("bnc_cnt_e%0d", k), {24'd0, press_cnt_o}, (k >= 14) ? 2 : 1);
    end
    chk_eq("bnc_one_pulse", hi_cycles - hi0, 1);

    // Release bounce: 2-cycle low glitch while held.
    hi0 = hi_cycles;
    for (int k = 0; k < 20; k++) begin
      pb_in_i = (k == 0 || k == 1) ? 1'b0 : 1'b1;
      step();
      chk_eq($sformatf("rbnc_level_e%0d", k), {31'd0, pb_level_o}, 1);
    end
    chk_eq("rbnc_nopulse", hi_cycles - hi0, 0);
    chk_eq("rbnc_cnt", {24'd0, press_cnt_o}, 2);
    pb_in_i = 1'b0;
    repeat (10) step();
    chk_eq("rbnc_released", {31'd0, pb_level_o}, 0);

    // Wrap: reset mid-cycle, then 256 clean presses.
    #2 rst_i = 1'b1;
    #1;
    chk_eq("rst2_cnt", {24'd0, press_cnt_o}, 0);
    step();
    rst_i = 1'b0;
    hi0 = hi_cycles;
    rise0 = rises;
    for (int p = 0; p < 256; p++) begin
      pb_in_i = 1'b1;
      repeat (8) step();
      pb_in_i = 1'b0;
      repeat (8) step();
    end
    chk_eq("wrap_hi_cycles", hi_cycles - hi0, 256);
    chk_eq("wrap_rises", rises - rise0, 256);
    chk_eq("wrap_cnt", {24'd0, press_cnt_o}, 0);
    pb_in_i = 1'b1;
    repeat (8) step();
    pb_in_i = 1'b0;
    repeat (8) step();
    chk_eq("wrap_257", {24'd0, press_cnt_o}, 1);

    // Reset while qualifying a press (cnt = 2), button kept held.
    pb_in_i = 1'b1;
    repeat (4) step();  // after edge 3: PRESS_CHK with cnt = 2
    chk_eq("pchk_level", {31'd0, pb_level_o}, 0);
    #2 rst_i = 1'b1;
    #1;
    chk_eq("pchk_rst_cnt", {24'd0, press_cnt_o}, 0);
    chk_eq("pchk_rst_pulse", {31'd0, pulse_o}, 0);
    chk_eq("pchk_rst_level", {31'd0, pb_level_o}, 0);
    hi0 = hi_cycles;
    repeat (3) step();
    rst_i = 1'b0;
    base = 8'd0;
    for (int k = 0; k < 15; k++) begin
      step();
      chk_eq($sformatf("post_pulse_e%0d", k), {31'd0, pulse_o}, (k == 5) ? 1 : 0);
      chk_eq($sformatf("post_level_e%0d", k), {31'd0, pb_level_o}, (k >= 5) ? 1 : 0);
      chk_eq($sformatf("post_cnt_e%0d", k), {24'd0, press_cnt_o},
             {24'd0, base} + ((k >= 5) ? 32'd1 : 32'd0));
    end
    chk_eq("post_one_pulse", hi_cycles - hi0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the bench never hangs.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
